// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, decision
// encoding and the decision-to-flags decode.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      EQ = 2'b00,
      LT = 2'b01,
      GT = 2'b10
   } dec_t;

   typedef struct packed {
      logic lesser;
      logic greater;
      logic equal;
   } flags_t;

   // Exactly one flag is set for any legal decision code.
   function automatic flags_t dec_to_flags(input dec_t d);
      flags_t f;
      f = '0;
      case (d)
         LT:      f.lesser  = 1'b1;
         GT:      f.greater = 1'b1;
         default: f.equal   = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Combinational per-bit decision update for the serial comparator.
module serial_cmp_cell
   import serial_cmp_pkg::*;
#(
   parameter int MSB_FIRST = 1
) (
   input  logic [1:0] i_dec,
   input  logic       i_a_bit,
   input  logic       i_b_bit,
   output logic [1:0] o_dec_nxt
);

   // MSB-first locks on the first difference; LSB-first lets the latest
   // (more significant) difference overwrite earlier ones.
   always_comb begin
      o_dec_nxt = i_dec;
      if (i_a_bit != i_b_bit) begin
         if ((MSB_FIRST == 0) || (i_dec == EQ)) begin
            o_dec_nxt = i_a_bit ? GT : LT;
         end
      end
   end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator with start/valid/done handshake;
// the result flags are registered and held until the next start.
module serial_magnitude_comparator
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic in_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic result_valid,
   output logic lesser,
   output logic greater,
   output logic equal
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_dec;
   logic [1:0]    w_dec_nxt;
   logic          w_accept;
   logic          w_last;
   flags_t        w_flags;

   logic r_busy;
   logic r_done;
   logic r_result_valid;
   logic r_lesser;
   logic r_greater;
   logic r_equal;

   serial_cmp_cell #(
      .MSB_FIRST (MSB_FIRST)
   ) u_cell (
      .i_dec     (r_dec),
      .i_a_bit   (a_bit),
      .i_b_bit   (b_bit),
      .o_dec_nxt (w_dec_nxt)
   );

   assign w_flags = dec_to_flags(dec_t'(w_dec_nxt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // start always wins, so a bit presented alongside start is never accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (!start && in_valid) begin
               w_accept = 1'b1;
               if (r_cnt == LAST_IDX) begin
                  w_last      = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt          <= '0;
         r_dec          <= EQ;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_result_valid <= 1'b0;
         r_lesser       <= 1'b0;
         r_greater      <= 1'b0;
         r_equal        <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == SHIFT);
         r_done <= w_last;
         if (start) begin
            r_cnt          <= '0;
            r_dec          <= EQ;
            r_result_valid <= 1'b0;
            r_lesser       <= 1'b0;
            r_greater      <= 1'b0;
            r_equal        <= 1'b0;
         end else if (w_accept) begin
            // Counter stops at WIDTH because the FSM leaves SHIFT here.
            r_cnt <= r_cnt + CW'(1);
            r_dec <= w_dec_nxt;
            if (w_last) begin
               r_result_valid <= 1'b1;
               r_lesser       <= w_flags.lesser;
               r_greater      <= w_flags.greater;
               r_equal        <= w_flags.equal;
            end
         end
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign result_valid = r_result_valid;
   assign lesser       = r_lesser;
   assign greater      = r_greater;
   assign equal        = r_equal;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: one MSB-first and one LSB-first
// instance, driven with directed and random operands against arithmetic compare.
module tb_serial_magnitude_comparator;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] start, in_valid, a_bit, b_bit;
   logic [1:0] busy, done, rv, lt, gt, eq;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt [2] = '{0, 0};

   // Index 0: LSB first, index 1: MSB first.
   serial_magnitude_comparator #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]),
      .a_bit(a_bit[0]), .b_bit(b_bit[0]), .busy(busy[0]), .done(done[0]),
      .result_valid(rv[0]), .lesser(lt[0]), .greater(gt[0]), .equal(eq[0])
   );

   serial_magnitude_comparator #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]),
      .a_bit(a_bit[1]), .b_bit(b_bit[1]), .busy(busy[1]), .done(done[1]),
      .result_valid(rv[1]), .lesser(lt[1]), .greater(gt[1]), .equal(eq[1])
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (done[i] === 1'b1) done_cnt[i]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_start(input int s, input logic iv, input string tag);
      start[s]    = 1'b1;
      in_valid[s] = iv;
      a_bit[s]    = 1'($urandom);
      b_bit[s]    = 1'($urandom);
      tick();
      start[s]    = 1'b0;
      in_valid[s] = 1'b0;
      chk({tag, "_st_busy"}, 32'(busy[s]), 32'd1);
      chk({tag, "_st_rv"}, 32'(rv[s]), 32'd0);
      chk({tag, "_st_flags"}, 32'({done[s], lt[s], gt[s], eq[s]}), 32'd0);
   endtask

   // Sends the first n bits of a/b in the instance's bit order, with n_stall
   // single idle cycles scattered before random bits (never before bit 0).
   task automatic send_bits(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int n, input int n_stall, input string tag);
      int stall_at [W];
      int bad_busy = 0;
      int early    = 0;
      int idx;
      for (int k = 0; k < W; k++) stall_at[k] = 0;
      repeat (n_stall) stall_at[$urandom_range(1, W - 1)]++;
      for (int k = 0; k < n; k++) begin
         repeat (stall_at[k]) begin
            in_valid[s] = 1'b0;
            a_bit[s]    = 1'($urandom);
            b_bit[s]    = 1'($urandom);
            tick();
            if (busy[s] !== 1'b1) bad_busy++;
            if (done[s] !== 1'b0) early++;
         end
         idx         = (s == 1) ? (W - 1 - k) : k;
         in_valid[s] = 1'b1;
         a_bit[s]    = a[idx];
         b_bit[s]    = b[idx];
         tick();
         in_valid[s] = 1'b0;
         if (k < n - 1) begin
            if (busy[s] !== 1'b1) bad_busy++;
            if (done[s] !== 1'b0) early++;
         end
      end
      chk({tag, "_busy_during"}, 32'(bad_busy), 32'd0);
      chk({tag, "_no_early_done"}, 32'(early), 32'd0);
   endtask

   task automatic run_cmp(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic iv_on_start, input int n_stall, input string tag);
      logic [2:0] exp_f;
      exp_f = {a < b, a > b, a == b};
      send_start(s, iv_on_start, tag);
      send_bits(s, a, b, W, n_stall, tag);
      chk({tag, "_done"}, 32'(done[s]), 32'd1);
      chk({tag, "_busy_off"}, 32'(busy[s]), 32'd0);
      chk({tag, "_rv"}, 32'(rv[s]), 32'd1);
      chk({tag, "_flags"}, 32'({lt[s], gt[s], eq[s]}), 32'(exp_f));
   endtask

   task automatic hold_check(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                             input string tag);
      logic [2:0] exp_f;
      exp_f = {a < b, a > b, a == b};
      in_valid[s] = 1'b1;
      a_bit[s]    = 1'($urandom);
      b_bit[s]    = 1'($urandom);
      tick();
      in_valid[s] = 1'b0;
      chk({tag, "_hold_done"}, 32'(done[s]), 32'd0);
      chk({tag, "_hold_rv"}, 32'(rv[s]), 32'd1);
      chk({tag, "_hold_flags"}, 32'({lt[s], gt[s], eq[s]}), 32'(exp_f));
   endtask

   task automatic check_all_zero(input string tag);
      for (int s = 0; s < 2; s++) begin
         chk(tag, 32'({busy[s], done[s], rv[s], lt[s], gt[s], eq[s]}), 32'd0);
      end
   endtask

   initial begin
      int dc0;
      int s;
      logic [W-1:0] ra, rb;

      rst_n    = 1'b0;
      start    = '0;
      in_valid = '0;
      a_bit    = '0;
      b_bit    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // in_valid in IDLE is ignored
      in_valid = 2'b11;
      repeat (3) begin
         a_bit = 2'($urandom);
         b_bit = 2'($urandom);
         tick();
         check_all_zero("idle_ignore");
      end
      in_valid = '0;

      // in_valid together with start is ignored
      run_cmp(1, 8'd96, 8'd96, 1'b1, 0, "iv_start");
      hold_check(1, 8'd96, 8'd96, "iv_start");

      // basic MSB-first lesser: done in cycle WIDTH+1 after start
      run_cmp(1, 8'd111, 8'd250, 1'b0, 0, "msb_lt");
      hold_check(1, 8'd111, 8'd250, "msb_lt");

      // back-to-back with start on the done cycle
      run_cmp(1, 8'd255, 8'd255, 1'b0, 0, "b2b_a");
      run_cmp(1, 8'd169, 8'd169, 1'b0, 0, "b2b_b");
      hold_check(1, 8'd169, 8'd169, "b2b_b");

      // LSB-first
      run_cmp(0, 8'd147, 8'd103, 1'b0, 0, "lsb_gt1");
      run_cmp(0, 8'd79, 8'd74, 1'b0, 0, "lsb_gt2");
      run_cmp(0, 8'd21, 8'd50, 1'b0, 0, "lsb_lt");
      hold_check(0, 8'd21, 8'd50, "lsb_lt");

      // stalls between bits
      run_cmp(1, 8'd85, 8'd25, 1'b0, 3, "stall");
      hold_check(1, 8'd85, 8'd25, "stall");

      // abort after 4 bits
      dc0 = done_cnt[1];
      send_start(1, 1'b0, "abort_pre");
      send_bits(1, 8'd199, 8'd220, 4, 0, "abort_pre");
      run_cmp(1, 8'd137, 8'd171, 1'b0, 0, "abort");
      hold_check(1, 8'd137, 8'd171, "abort");
      chk("abort_one_done", 32'(done_cnt[1] - dc0), 32'd1);

      // start together with the final bit discards it
      dc0 = done_cnt[0];
      send_start(0, 1'b0, "lastbit_pre");
      send_bits(0, 8'd200, 8'd3, W - 1, 0, "lastbit_pre");
      run_cmp(0, 8'd12, 8'd12, 1'b1, 0, "lastbit");
      hold_check(0, 8'd12, 8'd12, "lastbit");
      chk("lastbit_one_done", 32'(done_cnt[0] - dc0), 32'd1);

      // reset mid-operation
      dc0 = done_cnt[1];
      send_start(1, 1'b0, "rst_pre");
      send_bits(1, 8'd77, 8'd33, 5, 0, "rst_pre");
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid_async");
      in_valid[1] = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();
      in_valid[1] = 1'b0;
      check_all_zero("rst_mid_after");
      chk("rst_no_done", 32'(done_cnt[1] - dc0), 32'd0);

      // random operands, random instance, random stalls
      for (int it = 0; it < 40; it++) begin
         s  = int'($urandom_range(0, 1));
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         run_cmp(s, ra, rb, 1'($urandom), int'($urandom_range(0, 4)), "rand");
         if ($urandom_range(0, 1) == 1) hold_check(s, ra, rb, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Bit-serial unsigned magnitude comparator: the receiving end of a serial operand link.
- Accepts two WIDTH-bit operands one bit pair per accepted cycle, and produces the same Lesser/Greater/Equal result set as the parallel N-bit comparator.
- Sits downstream of an operand shift-register transmitter, where pin or area budget rules out a parallel bus.
- Start/valid/done handshake; the result is held until the next start.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- MSB_FIRST, 1, 1 = bits arrive MSB first; 0 = LSB first.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; clears state and opens a new comparison.
- in_valid  input  1  a_bit/b_bit valid this cycle.
- a_bit  input  1  serial bit of operand a.
- b_bit  input  1  serial bit of operand b.
- busy  output  1  high while collecting bits.
- done  output  1  one-cycle pulse when the result becomes valid.
- result_valid  output  1  high from done until the next start.
- lesser  output  1  a < b.
- greater  output  1  a > b.
- equal  output  1  a == b.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, result_valid=0, lesser=greater=equal=0, bit counter=0, decision register=EQ.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE/DONE --start--> SHIFT.
  - SHIFT --WIDTH-th accepted bit--> DONE.
  - SHIFT --start--> SHIFT (abort and restart).
- On start:
  - counter=0, decision=EQ, result_valid=0, lesser/greater/equal=0.
  - busy=1 from the next cycle.
- Bit acceptance:
  - A bit is accepted only when state==SHIFT, in_valid=1 and start=0.
  - in_valid in the same cycle as start is ignored; the first bit is taken in the following cycle at the earliest.
  - in_valid low in SHIFT is a stall: state, counter and decision are held with no timeout.
  - in_valid in IDLE or DONE is ignored.
- Decision update per accepted bit (a_bit != b_bit gives GT if a_bit=1, else LT):
  - MSB_FIRST=1: the decision is written only while decision==EQ. The first differing bit decides; later bits are still consumed.
  - MSB_FIRST=0: the decision is overwritten by every differing bit, so the last differing bit (the most significant) decides.
  - Equal bits never change the decision.
- Fixed length: exactly WIDTH bits are always consumed, with no early termination.
- Counter width is clog2(WIDTH+1). On the WIDTH-th accepted bit the counter does not wrap; it holds until the next start.
- Latency: done pulses the cycle after the WIDTH-th accepted bit. In that same cycle:
  - busy drops to 0 and result_valid rises to 1.
  - lesser/greater/equal take their registered values.
  - Exactly one of the three flags is 1.
- Minimum comparison time, start to done: WIDTH+1 cycles.
- Result hold: flags and result_valid stay stable in DONE until start. Repeated starts are legal back-to-back.
- Simultaneous events:
  - start in the cycle done pulses: the restart wins and result_valid drops the next cycle.
  - start in the cycle the final bit is presented: that bit is discarded, a restart occurs, and no done is produced.
- Reset mid-operation: everything returns to reset values immediately and no done is produced.
- Flags: registered outputs with no combinational input-to-output path.

Decomposition:
- Shared package serial_cmp_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - 2-bit decision encoding (EQ=2'b00, LT=2'b01, GT=2'b10);
  - decision-to-flags decode function, reused by the transmitter-side model.
- Natural sub-module: serial_cmp_cell, a combinational decision update from (decision, a_bit, b_bit, MSB_FIRST) to next decision.
- FSM, counter and output registers stay in the top.

Test Plan:
- MSB_FIRST=1, a=111, b=250, bits on consecutive cycles -> done at cycle 9 after start; lesser=1, greater=0, equal=0.
- MSB_FIRST=1, a=255, b=255, then a=169, b=169 back-to-back with start on the cycle done pulses -> equal=1 for each, with result_valid dropping between the two comparisons.
- MSB_FIRST=0, a=147, b=103, then a=79, b=74 -> greater=1 for both; a=21, b=50 -> lesser=1.
- MSB_FIRST=1, a=85, b=25 with in_valid low for 3 random cycles between bits -> greater=1, done exactly 1 cycle after the 8th accepted bit, busy=1 throughout the stalls.
- Abort: start, send 4 bits of a=199, b=220, re-assert start, send a full a=137, b=171 -> single done, lesser=1. Separately, rst_n low after 5 bits -> all outputs 0, no done.
- in_valid asserted together with start, and in IDLE -> those bits are ignored. a=96, b=96 sent from the next cycle -> equal=1.
